// File: rtl/clip_sequencer.sv
// Record/playback sequencer for the clip recorder: per-clip lengths, one clip active at a time.
// Optional LOOP_PLAYBACK_EN: playback wraps to the start of the clip instead of ending.
module clip_sequencer #(
    parameter int ADDR_W = 14,
    parameter int CLIP_W = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     play_pulse,
    input  logic                     record_pulse,
    input  logic                     clip_play_pulse,
    input  logic                     clip_rec_pulse,
    input  logic                     clear_pulse,
    input  logic                     sample_tick,
    output logic [CLIP_W+ADDR_W-1:0] mem_addr,
    output logic                     mem_we,
    output logic                     mem_re,
    output logic [CLIP_W-1:0]        play_clip,
    output logic [CLIP_W-1:0]        rec_clip,
    output logic [1:0]               state,
    output logic                     done
);

    localparam int NUM_CLIPS = 1 << CLIP_W;

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_RECORD = 2'b01;
    localparam logic [1:0] ST_PLAY   = 2'b10;

    localparam logic [ADDR_W-1:0] OFFSET_LAST = '1;
    localparam logic [ADDR_W:0]   LEN_ONE     = {{ADDR_W{1'b0}}, 1'b1};

    logic [1:0]               state_q, state_d;
    logic [ADDR_W-1:0]        offset_q, offset_d;
    logic [ADDR_W:0]          length_q [NUM_CLIPS];
    logic [CLIP_W-1:0]        play_clip_q, play_clip_d;
    logic [CLIP_W-1:0]        rec_clip_q, rec_clip_d;
    logic [CLIP_W+ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic                     mem_we_q, mem_we_d;
    logic                     mem_re_q, mem_re_d;
    logic                     done_q, done_d;

    logic                     len_we;
    logic                     len_clear;
    logic [ADDR_W:0]          len_wdata;
    logic [ADDR_W:0]          play_len;
    logic [ADDR_W:0]          play_last_off;
    logic                     play_last;

    assign play_len      = length_q[play_clip_q];
    assign play_last_off = play_len - LEN_ONE;
    assign play_last     = ({1'b0, offset_q} == play_last_off);

    // A tick coincident with the stop pulse is still written, so it is counted.
    assign len_wdata = {1'b0, offset_q} + {{ADDR_W{1'b0}}, sample_tick};

    always_comb begin
        state_d     = state_q;
        offset_d    = offset_q;
        play_clip_d = play_clip_q;
        rec_clip_d  = rec_clip_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;
        done_d      = 1'b0;
        len_we      = 1'b0;
        len_clear   = 1'b0;

        if (clear_pulse) begin
            state_d   = ST_IDLE;
            offset_d  = '0;
            len_clear = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (record_pulse) begin
                        state_d  = ST_RECORD;
                        offset_d = '0;
                    end else if (play_pulse && (play_len != '0)) begin
                        state_d  = ST_PLAY;
                        offset_d = '0;
                    end
                    if (clip_play_pulse) begin
                        play_clip_d = play_clip_q + 1'b1;
                    end
                    if (clip_rec_pulse) begin
                        rec_clip_d = rec_clip_q + 1'b1;
                    end
                end

                ST_RECORD: begin
                    if (sample_tick) begin
                        mem_we_d   = 1'b1;
                        mem_addr_d = {rec_clip_q, offset_q};
                        offset_d   = offset_q + 1'b1;
                    end
                    // Writing the last offset fills the clip and ends the take.
                    if (record_pulse || (sample_tick && (offset_q == OFFSET_LAST))) begin
                        len_we  = 1'b1;
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end

                ST_PLAY: begin
                    if (sample_tick) begin
                        mem_re_d   = 1'b1;
                        mem_addr_d = {play_clip_q, offset_q};
                        if (play_last) begin
                            offset_d = '0;
`ifdef LOOP_PLAYBACK_EN
`else
                            state_d  = ST_IDLE;
                            done_d   = 1'b1;
`endif
                        end else begin
                            offset_d = offset_q + 1'b1;
                        end
                    end
                    if (play_pulse) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            offset_q    <= '0;
            play_clip_q <= '0;
            rec_clip_q  <= '0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            offset_q    <= offset_d;
            play_clip_q <= play_clip_d;
            rec_clip_q  <= rec_clip_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            done_q      <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CLIPS; i++) begin
            if (reset || len_clear) begin
                length_q[i] <= '0;
            end else if (len_we && (rec_clip_q == CLIP_W'(i))) begin
                length_q[i] <= len_wdata;
            end
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;
    assign play_clip = play_clip_q;
    assign rec_clip  = rec_clip_q;
    assign state     = state_q;
    assign done      = done_q;

endmodule

// File: tb/tb_clip_sequencer.sv
// Directed bench for clip_sequencer (ADDR_W=4, CLIP_W=1) with a scoreboard of memory/done events.
module tb_clip_sequencer;

    localparam int ADDR_W = 4;
    localparam int CLIP_W = 1;
    localparam int AW     = CLIP_W + ADDR_W;
    localparam int EW     = AW + 3;

`ifdef LOOP_PLAYBACK_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    localparam logic [5:0] P_PLAY  = 6'b100000;
    localparam logic [5:0] P_REC   = 6'b010000;
    localparam logic [5:0] P_CPLAY = 6'b001000;
    localparam logic [5:0] P_CREC  = 6'b000100;
    localparam logic [5:0] P_CLR   = 6'b000010;
    localparam logic [5:0] P_TICK  = 6'b000001;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          play_pulse = 1'b0;
    logic          record_pulse = 1'b0;
    logic          clip_play_pulse = 1'b0;
    logic          clip_rec_pulse = 1'b0;
    logic          clear_pulse = 1'b0;
    logic          sample_tick = 1'b0;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic          mem_re;
    logic [CLIP_W-1:0] play_clip;
    logic [CLIP_W-1:0] rec_clip;
    logic [1:0]    state;
    logic          done;

    logic [EW-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    clip_sequencer #(.ADDR_W(ADDR_W), .CLIP_W(CLIP_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .play_pulse      (play_pulse),
        .record_pulse    (record_pulse),
        .clip_play_pulse (clip_play_pulse),
        .clip_rec_pulse  (clip_rec_pulse),
        .clear_pulse     (clear_pulse),
        .sample_tick     (sample_tick),
        .mem_addr        (mem_addr),
        .mem_we          (mem_we),
        .mem_re          (mem_re),
        .play_clip       (play_clip),
        .rec_clip        (rec_clip),
        .state           (state),
        .done            (done)
    );

    // clock / reset
    always #5 clk = ~clk;

    function automatic logic [EW-1:0] ev(input logic we, input logic re, input logic dn, input int addr);
        return {we, re, dn, AW'(addr)};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // one cycle of the given pulse pattern, then all pulses low
    task automatic step(input logic [5:0] v);
        {play_pulse, record_pulse, clip_play_pulse, clip_rec_pulse, clear_pulse, sample_tick} = v;
        @(posedge clk);
        #1;
        {play_pulse, record_pulse, clip_play_pulse, clip_rec_pulse, clear_pulse, sample_tick} = '0;
    endtask

    task automatic tick();
        step(P_TICK);
        step(6'b0);
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (!reset && (mem_we || mem_re || done)) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event: got we=%0b re=%0b done=%0b addr=0x%0h expected no event",
                         mem_we, mem_re, done, mem_addr);
            end else begin
                logic [EW-1:0] e;
                e = exp_q.pop_front();
                if ({mem_we, mem_re, done, mem_addr} !== e) begin
                    n_fail++;
                    $display("FAIL mem_event: got we=%0b re=%0b done=%0b addr=0x%0h expected we=%0b re=%0b done=%0b addr=0x%0h",
                             mem_we, mem_re, done, mem_addr, e[EW-1], e[EW-2], e[EW-3], e[AW-1:0]);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_state", int'(state), 0);
        chk("reset_addr", int'(mem_addr), 0);
        chk("reset_strobes", int'({mem_we, mem_re, done}), 0);
        chk("reset_clips", int'({play_clip, rec_clip}), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // record 5 samples into clip 0, stop with record_pulse
        step(P_REC);
        chk("rec_start_state", int'(state), 1);
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(ev(1, 0, 0, i));
            tick();
        end
        exp_q.push_back(ev(0, 0, 1, 4));
        step(P_REC);
        chk("rec_stop_state", int'(state), 0);

        // clip 1, record until full
        step(P_CREC);
        chk("rec_clip_adv", int'(rec_clip), 1);
        step(P_REC);
        for (int i = 0; i < 20; i++) begin
            if (i < 16) exp_q.push_back(ev(1, 0, (i == 15), 16 + i));
            tick();
        end
        chk("rec_full_state", int'(state), 0);

        // play clip 1 (16 samples)
        step(P_CPLAY);
        chk("play_clip_adv", int'(play_clip), 1);
        step(P_PLAY);
        chk("play_start_state", int'(state), 2);
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(ev(0, 1, (i == 15) && !LOOP, 16 + i));
            tick();
            if (i == 3) begin
                step(P_CPLAY);
                chk("play_clip_locked", int'(play_clip), 1);
            end
        end
        if (LOOP) exp_q.push_back(ev(0, 1, 0, 16));
        tick();
        if (LOOP) begin
            exp_q.push_back(ev(0, 0, 1, 16));
            step(P_PLAY);
        end
        chk("play_end_state", int'(state), 0);

        // play clip 0 (5 samples)
        step(P_CPLAY);
        chk("play_clip_wrap", int'(play_clip), 0);
        step(P_PLAY);
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(ev(0, 1, (i == 4) && !LOOP, i));
            tick();
        end
        if (LOOP) begin
            exp_q.push_back(ev(0, 0, 1, 4));
            step(P_PLAY);
        end
        chk("play0_end_state", int'(state), 0);

        // early stop with coincident tick
        step(P_PLAY);
        exp_q.push_back(ev(0, 1, 0, 0));
        tick();
        exp_q.push_back(ev(0, 1, 0, 1));
        tick();
        exp_q.push_back(ev(0, 1, 1, 2));
        step(P_PLAY | P_TICK);
        chk("play_early_stop_state", int'(state), 0);

        // record with tick coincident with stop: 2 samples counted
        step(P_REC);
        exp_q.push_back(ev(1, 0, 0, 16));
        tick();
        exp_q.push_back(ev(1, 0, 1, 17));
        step(P_REC | P_TICK);
        chk("rec_coinc_state", int'(state), 0);
        step(P_CPLAY);
        step(P_PLAY);
        chk("play2_state", int'(state), 2);
        exp_q.push_back(ev(0, 1, 0, 16));
        tick();
        exp_q.push_back(ev(0, 1, !LOOP, 17));
        tick();
        if (LOOP) begin
            exp_q.push_back(ev(0, 0, 1, 17));
            step(P_PLAY);
        end
        chk("play2_end_state", int'(state), 0);

        // clear erases lengths; play of empty clip ignored
        step(P_CLR);
        chk("clear_state", int'(state), 0);
        step(P_CPLAY);
        chk("play_clip_after_clear", int'(play_clip), 0);
        step(P_PLAY);
        chk("play_empty_state", int'(state), 0);
        tick();

        // clear mid-record: no done
        step(P_REC);
        chk("rec2_state", int'(state), 1);
        exp_q.push_back(ev(1, 0, 0, 16));
        tick();
        exp_q.push_back(ev(1, 0, 0, 17));
        tick();
        step(P_CLR);
        chk("clear_mid_rec_state", int'(state), 0);
        chk("clear_keeps_rec_clip", int'(rec_clip), 1);
        repeat (2) step(6'b0);

        // play+record together in IDLE: record wins; stop before any tick -> length 0
        step(P_PLAY | P_REC);
        chk("both_pulses_state", int'(state), 1);
        exp_q.push_back(ev(0, 0, 1, 17));
        step(P_REC);
        chk("rec_empty_stop_state", int'(state), 0);
        step(P_CPLAY);
        step(P_PLAY);
        chk("play_zero_len_state", int'(state), 0);
        tick();

        repeat (3) step(6'b0);
        chk("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
